// File: rtl/sb_slot_manager.sv
// sb_slot_manager: 8-slot store buffer with in-order drain to memory.
// Stores are allocated into the lowest free slot. A small order queue of
// slot IDs records allocation order, so memory sees stores in issue order.
// Optional feature macro: SB_FLUSH_EN adds flush_i, which discards every
// buffered entry.
module sb_slot_manager #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
`ifdef SB_FLUSH_EN
   input  logic              flush_i,
`endif
   input  logic              st_valid_i,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [DATA_W-1:0] st_data_i,
   output logic              st_ready_o,
   output logic              mem_valid_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              mem_ready_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [3:0]        count_o
);

   logic [7:0]        slot_valid;
   logic [ADDR_W-1:0] slot_addr [8];
   logic [DATA_W-1:0] slot_data [8];
   logic [2:0]        order_q   [8];
   logic [2:0]        head;
   logic [2:0]        tail;
   logic [3:0]        count;
   logic [2:0]        alloc_slot;
   logic              accept;
   logic              drain;
   logic              flush;

`ifdef SB_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   // A full buffer never accepts, even when a drain frees a slot on the same edge.
   assign st_ready_o  = (count < 4'd8) && !flush;
   assign mem_valid_o = (count != 4'd0);
   assign accept      = st_valid_i && st_ready_o;
   assign drain       = mem_valid_o && mem_ready_i;

   assign full_o  = (count == 4'd8);
   assign empty_o = (count == 4'd0);
   assign count_o = count;

   // Oldest entry is the slot named at the head of the order queue.
   assign mem_addr_o = slot_addr[order_q[head]];
   assign mem_data_o = slot_data[order_q[head]];

   // Lowest-index free slot from the pre-edge mask; the head slot is still
   // marked valid, so a slot freed on this edge cannot be picked until the next.
   always_comb begin
      // NOTE: the default assignment before the loop keeps this purely
      // combinational; without it a full mask would leave alloc_slot unassigned
      // and infer a latch.
      alloc_slot = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!slot_valid[i]) alloc_slot = 3'(i);
      end
   end

   // Control state: valid mask, order-queue pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid <= 8'd0;
         head       <= 3'd0;
         tail       <= 3'd0;
         count      <= 4'd0;
      end else if (flush) begin
         slot_valid <= 8'd0;
         head       <= 3'd0;
         tail       <= 3'd0;
         count      <= 4'd0;
      end else begin
         // NOTE: non-blocking assignments here so every read in this block
         // sees the pre-edge value, matching the hardware register behaviour.
         if (accept) begin
            slot_valid[alloc_slot] <= 1'b1;
            tail                   <= tail + 3'd1;
         end
         if (drain) begin
            slot_valid[order_q[head]] <= 1'b0;
            head                      <= head + 3'd1;
         end
         if (accept && !drain) begin
            count <= count + 4'd1;
         end else if (drain && !accept) begin
            count <= count - 4'd1;
         end
      end
   end

   // Slot payload and order queue: written on accept only.
   always_ff @(posedge clk) begin
      // NOTE: these arrays are deliberately not reset; the valid mask and count
      // decide which entries mean anything, so stale contents are harmless.
      if (accept) begin
         slot_addr[alloc_slot] <= st_addr_i;
         slot_data[alloc_slot] <= st_data_i;
         order_q[tail]         <= alloc_slot;
      end
   end

endmodule

// File: tb/tb_sb_slot_manager.sv
// tb_sb_slot_manager: checks sb_slot_manager against a queue-based reference
// model every cycle, plus directed scenarios with literal expectations.
// Build with SB_FLUSH_EN defined to also exercise flush_i.
module tb_sb_slot_manager;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st_valid_i = 1'b0;
   logic [31:0] st_addr_i = '0;
   logic [31:0] st_data_i = '0;
   logic        st_ready_o;
   logic        mem_valid_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_ready_i = 1'b0;
   logic        full_o;
   logic        empty_o;
   logic [3:0]  count_o;
   logic        flush_i = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   sb_slot_manager #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef SB_FLUSH_EN
      .flush_i    (flush_i),
`endif
      .st_valid_i (st_valid_i),
      .st_addr_i  (st_addr_i),
      .st_data_i  (st_data_i),
      .st_ready_o (st_ready_o),
      .mem_valid_o(mem_valid_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_o (mem_data_o),
      .mem_ready_i(mem_ready_i),
      .full_o     (full_o),
      .empty_o    (empty_o),
      .count_o    (count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO of entries in issue order, plus the slot-use mask.
   typedef struct {
      logic [2:0]  slot;
      logic [31:0] addr;
      logic [31:0] data;
   } ent_t;

   ent_t       mq[$];
   logic [7:0] mused = '0;
   bit         m_acc;
   bit         m_drn;
   int         m_free;

   always @(posedge clk or posedge rst) begin
      if (rst || flush_i) begin
         mq.delete();
         mused = '0;
      end else begin
         m_acc  = st_valid_i && (mq.size() < 8);
         m_drn  = (mq.size() > 0) && mem_ready_i;
         m_free = -1;
         for (int i = 0; i < 8; i++) if (!mused[i] && m_free < 0) m_free = i;
         if (m_drn) begin
            mused[mq[0].slot] = 1'b0;
            void'(mq.pop_front());
         end
         if (m_acc) begin
            mq.push_back('{slot: 3'(m_free), addr: st_addr_i, data: st_data_i});
            mused[m_free] = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("st_ready", st_ready_o, (mq.size() < 8) && !flush_i);
         check("mem_valid", mem_valid_o, mq.size() != 0);
         check("full", full_o, mq.size() == 8);
         check("empty", empty_o, mq.size() == 0);
         check("count", count_o, mq.size());
         check("slot_mask", dut.slot_valid, mused);
         if (mq.size() > 0) begin
            check("mem_addr", mem_addr_o, mq[0].addr);
            check("mem_data", mem_data_o, mq[0].data);
         end
      end
   end

   logic [31:0] dlog[$];
   logic [31:0] issued[$];
   bit          dummy;

   // One clock: drive, observe at negedge, advance past the edge.
   task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input bit r, output bit acc);
      st_valid_i  = v;
      st_addr_i   = a;
      st_data_i   = d;
      mem_ready_i = r;
      @(negedge clk);
      acc = v && st_ready_o;
      if (mem_valid_o && r) dlog.push_back(mem_addr_o);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      st_valid_i = 1'b0;
      mem_ready_i = 1'b0;
      flush_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      dlog.delete();
   endtask

   initial begin
      int  k;
      int  guard;
      bit  acc;
      logic [31:0] a;

      // Reset state, observed while rst is held.
      #1;
      check("rst_st_ready", st_ready_o, 1);
      check("rst_mem_valid", mem_valid_o, 0);
      check("rst_full", full_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_count", count_o, 0);
      do_reset();

      // Three stores with memory stalled.
      for (int i = 0; i < 3; i++) cyc(1, 32'h100 + 32'(i), 32'hD00 + 32'(i), 0, dummy);
      check("s3_count", count_o, 3);
      check("s3_mask", dut.slot_valid, 8'h07);
      check("s3_addr", mem_addr_o, 32'h100);
      cyc(0, 0, 0, 0, dummy);
      check("s3_addr_stable", mem_addr_o, 32'h100);

      // Fill to 8, then try a 9th store.
      for (int i = 3; i < 8; i++) cyc(1, 32'h100 + 32'(i), 32'hD00 + 32'(i), 0, dummy);
      check("full_flag", full_o, 1);
      check("full_ready", st_ready_o, 0);
      cyc(1, 32'h1FF, 32'hDFF, 0, acc);
      check("ninth_blocked", acc, 0);
      check("ninth_count", count_o, 8);
      cyc(1, 32'h1FF, 32'hDFF, 1, acc);
      check("no_bypass_acc", acc, 0);
      check("no_bypass_count", count_o, 7);
      cyc(1, 32'h1FF, 32'hDFF, 0, acc);
      check("ninth_after_drain", acc, 1);
      check("ninth_count8", count_o, 8);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, dummy);
      check("drained_empty", empty_o, 1);
      check("dlog_size9", dlog.size(), 9);
      for (int i = 0; i < 8; i++) if (i < dlog.size()) check("dlog_order", dlog[i], 32'h100 + 32'(i));
      if (dlog.size() > 8) check("dlog_ninth", dlog[8], 32'h1FF);

      // Lowest free slot reuse, drain still in issue order.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 32'h200 + 32'(i), 32'hE00 + 32'(i), 0, dummy);
      cyc(0, 0, 0, 1, dummy);
      cyc(0, 0, 0, 1, dummy);
      cyc(1, 32'h2BB, 32'hEBB, 0, dummy);
      check("reuse_mask", dut.slot_valid, 8'h0D);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, dummy);
      check("reuse_dlog_size", dlog.size(), 5);
      if (dlog.size() == 5) begin
         check("reuse_d2", dlog[2], 32'h202);
         check("reuse_d3", dlog[3], 32'h203);
         check("reuse_d4", dlog[4], 32'h2BB);
      end

      // Accept and drain on the same edge at count 4.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(i), 32'hF00 + 32'(i), 0, dummy);
      cyc(1, 32'h3AA, 32'hFAA, 1, dummy);
      check("simul_count", count_o, 4);
      check("simul_mask", dut.slot_valid, 8'h1E);

      // Asynchronous reset mid-transfer.
      st_valid_i  = 1'b1;
      mem_ready_i = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", count_o, 0);
      check("arst_empty", empty_o, 1);
      check("arst_mem_valid", mem_valid_o, 0);
      check("arst_mask", dut.slot_valid, 8'h00);
      do_reset();

      // Randomised traffic: 20 stores, random backpressure.
      issued.delete();
      k = 0;
      guard = 0;
      while ((k < 20 || mem_valid_o) && guard < 2000) begin
         a = 32'h4000 + 32'(k) * 32'h10;
         cyc((k < 20) && ($urandom_range(0, 1) == 1), a, $urandom, $urandom_range(0, 1) == 1, acc);
         if (acc) begin
            issued.push_back(a);
            k++;
         end
         guard++;
      end
      check("rand_no_timeout", guard < 2000, 1);
      check("rand_issued", issued.size(), 20);
      check("rand_drained", dlog.size(), 20);
      for (int i = 0; i < 20; i++)
         if (i < dlog.size() && i < issued.size()) check("rand_order", dlog[i], issued[i]);
      check("rand_empty", empty_o, 1);

`ifdef SB_FLUSH_EN
      // Flush beats a same-cycle accept and drain.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 32'h500 + 32'(i), 32'h0, 0, dummy);
      flush_i = 1'b1;
      cyc(1, 32'h5FF, 32'h0, 1, acc);
      flush_i = 1'b0;
      check("flush_acc", acc, 0);
      check("flush_count", count_o, 0);
      check("flush_empty", empty_o, 1);
      check("flush_mask", dut.slot_valid, 8'h00);
`endif

      st_valid_i  = 1'b0;
      mem_ready_i = 1'b0;
      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
